// File: rtl/upg_loader.sv
// UART upgrade loader: parses SEG/CNT/payload frames into 32-bit memory writes.
// Define UPG_CHECKSUM_EN to require a trailing XOR checksum byte after the last segment.
module upg_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_err_o,
    output logic        busy_o
);

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0] MAX_WORDS = 16'd16384;

    typedef enum logic [2:0] {IDLE, CNT0, CNT1, PAYLOAD, CHECK, DONE} state_t;

    state_t             state_q, state_d;
    logic               in_frame_q, in_frame_d;
    logic               seg_q, seg_d;
    logic               last_q, last_d;
    logic [7:0]         cnt_lo_q, cnt_lo_d;
    logic [14:0]        cnt_q, cnt_d;
    logic [14:0]        idx_q, idx_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [23:0]        sh_q, sh_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               wen_q, wen_d;
    logic [14:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]         xsum_q, xsum_d;
`endif

    logic               seg_end;
    logic               go_err;
    logic               timeout;
    logic [15:0]        n_words;

    assign busy_o     = in_frame_q || ((state_q != IDLE) && (state_q != DONE));
    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign upg_err_o  = err_q;

    always_comb begin
        state_d    = state_q;
        in_frame_d = in_frame_q;
        seg_d      = seg_q;
        last_d     = last_q;
        cnt_lo_d   = cnt_lo_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        sh_d       = sh_q;
        wen_d      = 1'b0;
        adr_d      = adr_q;
        dat_d      = dat_q;
        done_d     = done_q;
        err_d      = err_q;
        seg_end    = 1'b0;
        go_err     = 1'b0;
        n_words    = {rx_data, cnt_lo_q};

        // Inter-byte gap only counts while a frame is in progress
        gap_d   = (!busy_o || rx_valid) ? '0 : gap_q + 1'b1;
        timeout = busy_o && !rx_valid && (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

`ifdef UPG_CHECKSUM_EN
        xsum_d = xsum_q;
        if (rx_valid && (state_q != CHECK)) begin
            xsum_d = (in_frame_q || (state_q == CNT0) || (state_q == CNT1) || (state_q == PAYLOAD))
                     ? (xsum_q ^ rx_data) : rx_data;
        end
`endif

        case (state_q)
            IDLE, DONE: begin
                if (rx_valid) begin
                    seg_d      = rx_data[0];
                    last_d     = rx_data[7];
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    idx_d      = '0;
                    bcnt_d     = '0;
                    in_frame_d = 1'b1;
                    state_d    = CNT0;
                end
            end
            CNT0: begin
                if (rx_valid) begin
                    cnt_lo_d = rx_data;
                    state_d  = CNT1;
                end
            end
            CNT1: begin
                if (rx_valid) begin
                    if (n_words == 16'd0) begin
                        seg_end = 1'b1;
                    end else if (n_words > MAX_WORDS) begin
                        go_err = 1'b1;
                    end else begin
                        cnt_d   = n_words[14:0];
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    sh_d   = {rx_data, sh_q[23:8]};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wen_d = 1'b1;
                        adr_d = {seg_q, idx_q[13:0]};
                        dat_d = {rx_data, sh_q};
                        idx_d = idx_q + 15'd1;
                        if ((idx_q + 15'd1) == cnt_q) begin
                            seg_end = 1'b1;
                        end
                    end
                end
            end
            CHECK: begin
`ifdef UPG_CHECKSUM_EN
                if (rx_valid) begin
                    if (rx_data == xsum_q) begin
                        done_d     = 1'b1;
                        in_frame_d = 1'b0;
                        state_d    = DONE;
                    end else begin
                        go_err = 1'b1;
                    end
                end
`else
                done_d     = 1'b1;
                in_frame_d = 1'b0;
                state_d    = DONE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // A non-last segment parks in IDLE with in_frame held so busy_o stays high
        if (seg_end) begin
            state_d = last_q ? CHECK : IDLE;
        end

        if (go_err || timeout) begin
            err_d      = 1'b1;
            done_d     = 1'b0;
            in_frame_d = 1'b0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            in_frame_q <= 1'b0;
            seg_q      <= 1'b0;
            last_q     <= 1'b0;
            cnt_lo_q   <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            sh_q       <= '0;
            gap_q      <= '0;
            wen_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            xsum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            in_frame_q <= in_frame_d;
            seg_q      <= seg_d;
            last_q     <= last_d;
            cnt_lo_q   <= cnt_lo_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            sh_q       <= sh_d;
            gap_q      <= gap_d;
            wen_q      <= wen_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef UPG_CHECKSUM_EN
            xsum_q     <= xsum_d;
`endif
        end
    end

endmodule

// File: doc/upg_loader.md
UPG_LOADER -- requirements
Module: upg_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports named as below.
REQ-002 Parameter TIMEOUT_CYCLES SHALL default to 1000000 and set the maximum idle clocks between bytes inside a frame.
REQ-003 clk  in  1  system clock (10MHz UPG clock domain); all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 rx_data  in  8  received UART byte.
REQ-006 rx_valid  in  1  one-cycle strobe; rx_data valid this cycle.
REQ-007 upg_wen_o  out  1  one-cycle memory write strobe.
REQ-008 upg_adr_o  out  15  write address: bit14 = segment (0 instruction, 1 data), bits13:0 = word index.
REQ-009 upg_dat_o  out  32  write data word.
REQ-010 upg_done_o  out  1  level; high when the programming session is complete.
REQ-011 upg_err_o  out  1  level; sticky frame error.
REQ-012 busy_o  out  1  high in any state other than IDLE and DONE.

Function
REQ-013 The frame SHALL be a sequence of segments, each: SEG byte (bit0 = segment select, bit7 = last-segment flag, other bits ignored), CNT_LO, CNT_HI (16-bit word count N), then 4N payload bytes, each word little-endian.
REQ-014 The FSM SHALL have states IDLE, CNT0, CNT1, PAYLOAD, CHECK, DONE.
REQ-015 IDLE/DONE + rx_valid: latch SEG, clear upg_done_o and upg_err_o, clear word index and byte counter, go to CNT0.
REQ-016 CNT0 -> CNT1 on a byte; CNT1 -> PAYLOAD on a byte if 0 < N <= 16384; N = 0 -> segment end (REQ-019); N > 16384 -> error (REQ-021).
REQ-017 In PAYLOAD, bytes SHALL shift in LSB-first; on the 4th byte, upg_wen_o SHALL pulse on the next clock with upg_adr_o = {seg, index} and the assembled word; the index then increments.
REQ-018 upg_adr_o/upg_dat_o SHALL stay stable while upg_wen_o is high and hold their last value afterwards.
REQ-019 Segment end (N words written): last flag = 0 -> IDLE-equivalent header wait (CNT0 is entered on the next SEG byte, busy_o stays high); last flag = 1 -> CHECK.
REQ-020 CHECK -> DONE; upg_done_o SHALL go high one clock after the final upg_wen_o pulse (or after CNT_HI for N = 0) and hold until the next SEG byte in DONE.
REQ-021 Error (bad count, timeout, checksum mismatch): upg_err_o set, upg_done_o stays low, FSM to IDLE, no further writes for that frame.
REQ-022 The gap counter SHALL reset on every rx_valid and be active only while busy_o; reaching TIMEOUT_CYCLES SHALL trigger REQ-021.
REQ-023 Word index SHALL never wrap; index 16383 is the last legal address per segment.
REQ-024 rx_valid during a upg_wen_o pulse cycle SHALL be accepted without loss.

Reset
REQ-025 While rst is low: state IDLE, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, upg_err_o=0, busy_o=0, counters cleared, regardless of mid-frame position.
REQ-026 A reset asserted mid-frame SHALL discard the partial word; no write is issued for it.

Configuration
REQ-027 With UPG_CHECKSUM_EN defined, CHECK SHALL wait for one trailing byte equal to the XOR of all frame bytes from the first SEG to the last payload byte; a match gives DONE, a mismatch gives REQ-021; the timeout applies while waiting.
REQ-028 Without UPG_CHECKSUM_EN, CHECK SHALL last one clock and go unconditionally to DONE; no trailing byte is expected.

Verification
REQ-029 Frame 80 01 00 78 56 34 12 (no checksum) -> one upg_wen_o with adr 0x0000, dat 0x12345678; then upg_done_o=1, upg_err_o=0.
REQ-030 Frame 00 02 00 <8 bytes> 81 01 00 EF BE AD DE -> writes at 0x0000, 0x0001, then 0x4000 with dat 0xDEADBEEF; done after the third write.
REQ-031 SEG 80, count 01 40 (0x4001) -> upg_err_o=1, zero writes, done low, busy_o=0.
REQ-032 Frame stalls after 2 payload bytes for TIMEOUT_CYCLES clocks -> upg_err_o=1, no write; the next valid frame clears err and completes.
REQ-033 UPG_CHECKSUM_EN: 80 01 00 01 00 00 00 + checksum 80 -> done; same frame with checksum 81 -> upg_err_o=1 after one write at 0x0000.
REQ-034 rst pulled low after 3 payload bytes -> all outputs 0 immediately, no write; a full frame after release works.
